prog_rom: RTL and testbench

- Instruction memory answering the CPU's fetch port: the CPU drives a 4-bit instruction address and receives the 4-bit opcode and 4-bit immediate in the same cycle.
- 16 x 8-bit storage with an asynchronous read port.
- A byte-wide valid/ready loader replaces the program at runtime.
- Holds the CPU in reset through a dedicated reset output while a load is in progress.

---
 rtl/cpu_pkg.sv | 43 ++++
 rtl/prog_loader_fsm.sv | 167 ++++++++++++++++
 rtl/prog_rom.sv | 67 ++++++
 tb/tb_prog_rom.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared CPU definitions (opcode encoding, instruction word layout,
// power-on program) plus the loader state encoding used by prog_rom.
// Optional feature macro (used by prog_rom files): PROG_ROM_CHECKSUM_EN.
package cpu_pkg;

   localparam int CPU_AW    = 4;
   localparam int CPU_DEPTH = 16;
   localparam int CPU_IW    = 8;

   typedef enum logic [3:0] {
      ADD_A     = 4'd0,
      MOV_AB    = 4'd1,
      IN_A      = 4'd2,
      MOV_A_IMM = 4'd3,
      MOV_BA    = 4'd4,
      ADD_B     = 4'd5,
      IN_B      = 4'd6,
      MOV_B_IMM = 4'd7,
      OUT_B     = 4'd9,
      OUT_IMM   = 4'd11
   } opcode_t;

   typedef struct packed {
      logic [3:0] opecode;
      logic [3:0] imm;
   } instr_t;

   typedef enum logic [1:0] {
      ST_RUN  = 2'd0,
      ST_LOAD = 2'd1,
      ST_ERR  = 2'd2
   } load_state_t;

   // LED blink loop: even words OUT_IMM 3, odd words OUT_IMM 12 (word 0 is the LSB slot).
   localparam instr_t [CPU_DEPTH-1:0] DEFAULT_PROGRAM =
      {(CPU_DEPTH/2){{OUT_IMM, 4'd12}, {OUT_IMM, 4'd3}}};

   // Modulo-256 running sum used for the load checksum.
   function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
      return acc + b;
   endfunction

endpackage

// File: rtl/prog_loader_fsm.sv
// prog_loader_fsm: runtime program loader for prog_rom. Owns the load state,
// the write pointer, the checksum accumulator and the CPU reset output, and
// produces the write strobe/address into the instruction store.
// Optional feature macro: PROG_ROM_CHECKSUM_EN (adds a trailing checksum byte
// and an ERR state that keeps the CPU in reset on a bad load).
module prog_loader_fsm
   import cpu_pkg::*;
#(
   parameter int AW    = CPU_AW,
   parameter int DEPTH = CPU_DEPTH,
   parameter int IW    = CPU_IW
) (
   input  logic          clk,
   input  logic          n_rst,
   input  logic          prog_start,
`ifdef PROG_ROM_CHECKSUM_EN
   input  logic [IW-1:0] prog_data,
`endif
   input  logic          prog_valid,
   output logic          prog_ready,
   output logic          cpu_n_rst,
   output logic          loading,
   output logic          load_err,
   output logic          wr_en,
   output logic [AW-1:0] wr_addr
);

   localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);

   load_state_t   state_r;
   logic [AW-1:0] wr_ptr_r;
   logic          ready_r;
   logic          cpu_rst_r;
   logic          loading_r;
   logic          hs;
`ifdef PROG_ROM_CHECKSUM_EN
   logic [7:0]    csum_r;
   logic          csum_phase_r;   // all DEPTH words stored, next byte is the checksum
   logic          err_r;
`endif

   assign hs         = prog_valid & ready_r;
   assign prog_ready = ready_r;
   assign cpu_n_rst  = cpu_rst_r;
   assign loading    = loading_r;
   assign wr_addr    = wr_ptr_r;
`ifdef PROG_ROM_CHECKSUM_EN
   assign load_err   = err_r;
`else
   assign load_err   = 1'b0;
`endif

   // Write strobe: every accepted byte is stored except the trailing checksum.
   always_comb begin
      wr_en = 1'b0;
`ifdef PROG_ROM_CHECKSUM_EN
      if (hs && !csum_phase_r) begin
         wr_en = 1'b1;
      end else begin
         wr_en = 1'b0;
      end
`else
      wr_en = hs;
`endif
   end

   // Loader state machine with registered handshake and CPU reset outputs.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_r      <= ST_RUN;
         wr_ptr_r     <= '0;
         ready_r      <= 1'b0;
         cpu_rst_r    <= 1'b0;
         loading_r    <= 1'b0;
`ifdef PROG_ROM_CHECKSUM_EN
         csum_r       <= 8'h00;
         csum_phase_r <= 1'b0;
         err_r        <= 1'b0;
`endif
      end else begin
         case (state_r)
            ST_RUN: begin
               if (prog_start) begin
                  state_r      <= ST_LOAD;
                  wr_ptr_r     <= '0;
                  ready_r      <= 1'b1;
                  loading_r    <= 1'b1;
                  cpu_rst_r    <= 1'b0;
`ifdef PROG_ROM_CHECKSUM_EN
                  csum_r       <= 8'h00;
                  csum_phase_r <= 1'b0;
`endif
               end else begin
                  ready_r   <= 1'b0;
                  loading_r <= 1'b0;
                  cpu_rst_r <= 1'b1;
               end
            end
            ST_LOAD: begin
               // prog_start is deliberately ignored here: a load always runs to completion.
               cpu_rst_r <= 1'b0;
               if (hs) begin
`ifdef PROG_ROM_CHECKSUM_EN
                  if (csum_phase_r) begin
                     csum_phase_r <= 1'b0;
                     ready_r      <= 1'b0;
                     loading_r    <= 1'b0;
                     if (csum_add(csum_r, prog_data) == 8'h00) begin
                        state_r <= ST_RUN;
                        err_r   <= 1'b0;
                     end else begin
                        state_r <= ST_ERR;
                        err_r   <= 1'b1;
                     end
                  end else begin
                     csum_r   <= csum_add(csum_r, prog_data);
                     wr_ptr_r <= wr_ptr_r + PTR_ONE;
                     if (wr_ptr_r == LAST_PTR) begin
                        csum_phase_r <= 1'b1;
                     end else begin
                        csum_phase_r <= 1'b0;
                     end
                  end
`else
                  wr_ptr_r <= wr_ptr_r + PTR_ONE;
                  if (wr_ptr_r == LAST_PTR) begin
                     // Last word written: CPU is released on the following edge from RUN.
                     state_r   <= ST_RUN;
                     ready_r   <= 1'b0;
                     loading_r <= 1'b0;
                  end else begin
                     state_r <= ST_LOAD;
                  end
`endif
               end else begin
                  state_r <= ST_LOAD;
               end
            end
`ifdef PROG_ROM_CHECKSUM_EN
            ST_ERR: begin
               cpu_rst_r <= 1'b0;
               if (prog_start) begin
                  state_r      <= ST_LOAD;
                  wr_ptr_r     <= '0;
                  ready_r      <= 1'b1;
                  loading_r    <= 1'b1;
                  csum_r       <= 8'h00;
                  csum_phase_r <= 1'b0;
                  err_r        <= 1'b0;
               end else begin
                  ready_r   <= 1'b0;
                  loading_r <= 1'b0;
               end
            end
`endif
            default: begin
               state_r   <= ST_RUN;
               ready_r   <= 1'b0;
               loading_r <= 1'b0;
               cpu_rst_r <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/prog_rom.sv
// prog_rom: 16 x 8 instruction memory with a combinational fetch port and a
// byte-wide valid/ready runtime loader that holds the CPU in reset while a
// new program is being written. DEPTH must equal 2**AW.
// Optional feature macro: PROG_ROM_CHECKSUM_EN (checksum-verified loads).
module prog_rom
   import cpu_pkg::*;
#(
   parameter int DEPTH = CPU_DEPTH,
   parameter int AW    = CPU_AW,
   parameter int IW    = CPU_IW
) (
   input  logic          clk,
   input  logic          n_rst,
   input  logic [AW-1:0] addr,
   output logic [3:0]    opecode,
   output logic [3:0]    imm,
   input  logic          prog_start,
   input  logic [IW-1:0] prog_data,
   input  logic          prog_valid,
   output logic          prog_ready,
   output logic          cpu_n_rst,
   output logic          loading,
   output logic          load_err
);

   logic [IW-1:0] mem [DEPTH];
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   instr_t        rd_word;

   prog_loader_fsm #(
      .AW    (AW),
      .DEPTH (DEPTH),
      .IW    (IW)
   ) u_loader (
      .clk        (clk),
      .n_rst      (n_rst),
      .prog_start (prog_start),
`ifdef PROG_ROM_CHECKSUM_EN
      .prog_data  (prog_data),
`endif
      .prog_valid (prog_valid),
      .prog_ready (prog_ready),
      .cpu_n_rst  (cpu_n_rst),
      .loading    (loading),
      .load_err   (load_err),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr)
   );

   for (genvar g = 0; g < DEPTH; g++) begin : g_word
      // Storage word: reset to the blink program, overwritten by loader handshakes.
      always_ff @(posedge clk or negedge n_rst) begin
         if (!n_rst) begin
            mem[g] <= IW'(DEFAULT_PROGRAM[g]);
         end else if (wr_en && (wr_addr == AW'(g))) begin
            mem[g] <= prog_data;
         end
      end
   end

   // Fetch is asynchronous, so a same-cycle write shows up only after its edge.
   assign rd_word = instr_t'(mem[addr]);
   assign opecode = rd_word.opecode;
   assign imm     = rd_word.imm;

endmodule

// File: tb/tb_prog_rom.sv
// tb_prog_rom: directed scoreboard bench for prog_rom. Stimulus pushes
// expected observations into a queue; a monitor on the falling edge pops and
// compares them. Honours PROG_ROM_CHECKSUM_EN when defined.
module tb_prog_rom;

   logic       clk = 1'b0;
   logic       n_rst = 1'b0;
   logic [3:0] addr = 4'd0;
   logic [3:0] opecode;
   logic [3:0] imm;
   logic       prog_start = 1'b0;
   logic [7:0] prog_data = 8'h00;
   logic       prog_valid = 1'b0;
   logic       prog_ready;
   logic       cpu_n_rst;
   logic       loading;
   logic       load_err;

   localparam int S_INSTR = 0;
   localparam int S_CPU   = 1;
   localparam int S_LOAD  = 2;
   localparam int S_READY = 3;
   localparam int S_ERR   = 4;

   int         n_checks = 0;
   int         n_fail   = 0;
   int         sel_q[$];
   logic [7:0] val_q[$];
   string      name_q[$];

   int         m_sel;
   logic [7:0] m_exp;
   logic [7:0] m_act;
   string      m_name;

   prog_rom dut (
      .clk        (clk),
      .n_rst      (n_rst),
      .addr       (addr),
      .opecode    (opecode),
      .imm        (imm),
      .prog_start (prog_start),
      .prog_data  (prog_data),
      .prog_valid (prog_valid),
      .prog_ready (prog_ready),
      .cpu_n_rst  (cpu_n_rst),
      .loading    (loading),
      .load_err   (load_err)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic expect_val(input int sel, input logic [7:0] v, input string nm);
      sel_q.push_back(sel);
      val_q.push_back(v);
      name_q.push_back(nm);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] sample(input int sel);
      case (sel)
         S_INSTR: return {opecode, imm};
         S_CPU:   return {7'd0, cpu_n_rst};
         S_LOAD:  return {7'd0, loading};
         S_READY: return {7'd0, prog_ready};
         S_ERR:   return {7'd0, load_err};
         default: return 8'hxx;
      endcase
   endfunction

   // Scoreboard monitor: compare everything expected for this cycle mid-cycle.
   always @(negedge clk) begin
      while (sel_q.size() > 0) begin
         m_sel  = sel_q.pop_front();
         m_exp  = val_q.pop_front();
         m_name = name_q.pop_front();
         m_act  = sample(m_sel);
         n_checks++;
         if (m_act !== m_exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", m_name, m_act, m_exp);
         end
      end
   end

   // One handshake: present the byte, wait (bounded) for ready, complete on the edge.
   task automatic send_byte(input logic [7:0] d);
      int budget;
      budget = 0;
      prog_valid = 1'b1;
      prog_data  = d;
      while (!prog_ready && budget < 40) begin
         tick();
         budget++;
      end
      n_checks++;
      if (!prog_ready) begin
         n_fail++;
         $display("FAIL ready_timeout: prog_ready got 0 expected 1");
      end
      tick();
      prog_valid = 1'b0;
   endtask

   task automatic start_load();
      prog_start = 1'b1;
      tick();
      prog_start = 1'b0;
   endtask

   initial begin
      logic [7:0] d;
      logic [7:0] sum;

      // ---- reset state ----
      repeat (2) tick();
      expect_val(S_CPU,   8'h00, "rst_cpu_n_rst");
      expect_val(S_READY, 8'h00, "rst_prog_ready");
      expect_val(S_LOAD,  8'h00, "rst_loading");
      expect_val(S_ERR,   8'h00, "rst_load_err");
      expect_val(S_INSTR, 8'hB3, "rst_addr0");
      tick();
      n_rst = 1'b1;
      expect_val(S_CPU, 8'h00, "release_cycle0_cpu");
      tick();
      expect_val(S_CPU,   8'h01, "release_cycle1_cpu");
      expect_val(S_INSTR, 8'hB3, "default_addr0");
      tick();
      addr = 4'd1;
      expect_val(S_INSTR, 8'hBC, "default_addr1");
      tick();

      // ---- load 0x30..0x3F, valid gapped every other cycle ----
      addr = 4'd5;
      expect_val(S_INSTR, 8'hBC, "pre_load_addr5");
      start_load();
      expect_val(S_LOAD,  8'h01, "load_loading");
      expect_val(S_READY, 8'h01, "load_ready");
      expect_val(S_CPU,   8'h00, "load_cpu_rst");
      sum = 8'h00;
      for (int i = 0; i < 16; i++) begin
         prog_valid = 1'b0;
         tick();
         expect_val(S_CPU, 8'h00, "gap_cpu_rst");
         d = 8'h30 + 8'(i);
         sum = sum + d;
         send_byte(d);
      end
`ifdef PROG_ROM_CHECKSUM_EN
      send_byte(8'h00 - sum);
`endif
      expect_val(S_LOAD, 8'h00, "loading_drop");
      expect_val(S_CPU,  8'h00, "cpu_rst_last_cycle");
      tick();
      expect_val(S_CPU,   8'h01, "cpu_released");
      expect_val(S_INSTR, 8'h35, "loaded_addr5");
      tick();

      // ---- prog_start pulsed at byte 7 must not restart ----
      start_load();
      sum = 8'h00;
      for (int i = 0; i < 16; i++) begin
         d = 8'h40 + 8'(i);
         sum = sum + d;
         if (i == 7) prog_start = 1'b1;
         send_byte(d);
         prog_start = 1'b0;
         if (i == 7) expect_val(S_LOAD, 8'h01, "start_ignored_loading");
      end
`ifdef PROG_ROM_CHECKSUM_EN
      send_byte(8'h00 - sum);
`endif
      expect_val(S_LOAD, 8'h00, "restart_done_loading");
      addr = 4'd0;
      expect_val(S_INSTR, 8'h40, "restart_addr0");
      tick();
      addr = 4'd7;
      expect_val(S_INSTR, 8'h47, "restart_addr7");
      tick();
      addr = 4'd15;
      expect_val(S_INSTR, 8'h4F, "restart_addr15");
      tick();

      // ---- reset asserted after byte 9 ----
      start_load();
      for (int i = 0; i < 10; i++) send_byte(8'h50 + 8'(i));
      addr = 4'd0;
      n_rst = 1'b0;
      expect_val(S_INSTR, 8'hB3, "abort_addr0");
      expect_val(S_LOAD,  8'h00, "abort_loading");
      expect_val(S_CPU,   8'h00, "abort_cpu_rst");
      tick();
      n_rst = 1'b1;
      addr = 4'd9;
      expect_val(S_INSTR, 8'hBC, "abort_addr9_default");
      expect_val(S_READY, 8'h00, "abort_ready");
      tick();
      expect_val(S_LOAD, 8'h00, "abort_state_run");
      expect_val(S_CPU,  8'h01, "abort_cpu_released");
      tick();

      // ---- write/read collision on addr 4 ----
      addr = 4'd4;
      start_load();
      sum = 8'h00;
      for (int i = 0; i < 16; i++) begin
         d = (i == 4) ? 8'h7A : (8'h60 + 8'(i));
         sum = sum + d;
         if (i == 4) expect_val(S_INSTR, 8'hB3, "collide_old_word");
         send_byte(d);
         if (i == 4) expect_val(S_INSTR, 8'h7A, "collide_new_word");
      end
`ifdef PROG_ROM_CHECKSUM_EN
      send_byte(8'h00 - sum);
`endif
      tick();

`ifdef PROG_ROM_CHECKSUM_EN
      // ---- bad checksum: 0x30..0x3F sum to 0x78, so 0x00 is wrong ----
      start_load();
      for (int i = 0; i < 16; i++) send_byte(8'h30 + 8'(i));
      send_byte(8'h00);
      expect_val(S_ERR,   8'h01, "csum_bad_err");
      expect_val(S_CPU,   8'h00, "csum_bad_cpu_rst");
      expect_val(S_READY, 8'h00, "csum_bad_ready");
      tick();
      expect_val(S_CPU, 8'h00, "csum_err_hold_cpu");
      expect_val(S_ERR, 8'h01, "csum_err_sticky");
      start_load();
      expect_val(S_ERR,  8'h00, "csum_err_cleared");
      expect_val(S_LOAD, 8'h01, "csum_reload_loading");
      // ---- good checksum: 0x100 - 0x78 = 0x88 ----
      for (int i = 0; i < 16; i++) send_byte(8'h30 + 8'(i));
      send_byte(8'h88);
      expect_val(S_ERR,  8'h00, "csum_good_err");
      expect_val(S_LOAD, 8'h00, "csum_good_loading");
      tick();
      addr = 4'd5;
      expect_val(S_CPU,   8'h01, "csum_good_cpu");
      expect_val(S_INSTR, 8'h35, "csum_good_addr5");
      tick();
`endif

      repeat (2) tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
